mac_job_seq: RTL and testbench
==============================

Name: mac_job_seq

Overview:
- Job sequencer in front of one mac_int_fsm instance.
- Buffers signed 16-bit operand pairs in a small FIFO.
- Clears the MAC accumulator, issues one pair per MAC transaction and waits for each done.
- Returns the final accumulated 32-bit sum with a valid/ready handshake. Lets a systolic-array controller offload a whole dot product.

Parameters:
DEPTH, 4, operand FIFO entries (power of two, >=2)
LEN_W, 8, width of job length / op counter
TIMEOUT, 64, max cycles in WAIT before watchdog fires (used only with MAC_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
job_start  in  1  one-cycle pulse, start job
job_len  in  LEN_W  operand pairs in job, sampled with job_start
job_busy  out  1  high from accepted job_start until result handshake completes
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO not full
in_a  in  16  signed operand A
in_b  in  16  signed operand B
mac_clr  out  1  one-cycle clear to MAC reset (integration ORs with reset)
mac_valid  out  1  one-cycle launch pulse to MAC
mac_a  out  16  signed, registered, stable from launch until done
mac_b  out  16  signed, registered, stable from launch until done
mac_y  in  32  signed MAC accumulator output
mac_done  in  1  MAC completion pulse
res_valid  out  1  result available
res_ready  in  1  result consumed
res_y  out  32  signed final sum
res_count  out  LEN_W  pairs actually accumulated
timeout_err  out  1  watchdog fired on this result (tied 0 without macro)

Behaviour:
- Reset: every output 0; FIFO empty; state IDLE; counters 0. Reset mid-job abandons the job. FIFO contents are lost. mac_clr is not pulsed by the block; the external OR covers it.
- FIFO: push on in_valid&&in_ready; in_ready=!full, registered. Pushes are accepted in any state, including prefetch in IDLE. Pop only in ISSUE. Push and pop in the same cycle keep the count unchanged. Pointers wrap modulo DEPTH.
- IDLE:
  - job_start with job_len!=0: latch len, clear op count, go to CLEAR.
  - job_start with job_len==0: go to RESULT with res_y=0, res_count=0.
  - job_start in any non-IDLE state is ignored.
- CLEAR: mac_clr=1 for exactly one cycle, then ISSUE.
- ISSUE:
  - FIFO non-empty: pop; register mac_a/mac_b from head; mac_valid=1 for one cycle; go to WAIT.
  - FIFO empty: stay in ISSUE.
- WAIT: on mac_done, latch res_y<=mac_y and increment op count.
  - count==len: go to RESULT.
  - Otherwise: go to ISSUE.
  - mac_done outside WAIT is ignored.
- RESULT: res_valid=1. res_y, res_count and timeout_err are held stable until res_ready. On res_valid&&res_ready: go to IDLE and clear res_valid. The next job_start is accepted the cycle after.
- Latency with FIFO pre-filled: job_start at cycle T gives mac_clr at T+1 and first mac_valid at T+2. Each later pair launches one cycle after the previous mac_done.
- Arithmetic: no saturation in the block; res_y is the MAC's 32-bit wrap value as-is.

Optional Feature:
MAC_TIMEOUT_EN
- Defined:
  - Watchdog counts cycles in WAIT and restarts on each launch.
  - Reaching TIMEOUT without mac_done: pulse mac_clr, go to RESULT with res_y=last latched value, res_count=completed pairs, timeout_err=1.
  - Un-issued pairs of that job remain in the FIFO.
- Undefined: no watchdog; WAIT waits indefinitely; timeout_err constant 0.

Decomposition:
- Package mac_ctrl_pkg holds:
  - OPW=16 and ACCW=32 constants.
  - State enum: IDLE, CLEAR, ISSUE, WAIT, RESULT.
  - Operand-pair struct {a,b}.
- Sub-module mac_op_fifo: synchronous FIFO of operand-pair structs, parameter DEPTH, with full/empty outputs.

Test Plan:
- Prefill (30,40),(10,16),(50,25); job_len=3 -> mac_clr at T+1, three mac_valid pulses; res_y=2610, res_count=3, timeout_err=0.
- Pairs (100,-2),(11,-11),(-111,-2); job_len=3 -> res_y=-99.
- job_len=0 -> res_valid next cycle with res_y=0, res_count=0; no mac_clr or mac_valid.
- DEPTH=4, push 6 pairs while IDLE -> in_ready low after 4th push. Hold res_ready=0 for 5 cycles -> res_valid and res_y stable; job_start during that window ignored.
- Assert reset while in WAIT -> next cycle all outputs 0, in_ready=1, FIFO empty. A late mac_done is ignored.
- With MAC_TIMEOUT_EN and TIMEOUT=64, MAC never asserts done -> after 64 WAIT cycles mac_clr pulse, res_valid=1, timeout_err=1, res_count=0.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared types for the MAC job sequencer: operand/accumulator widths,
// sequencer state encoding and the operand-pair record held in the FIFO.
package mac_ctrl_pkg;

  localparam int OPW  = 16;
  localparam int ACCW = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    RESULT
  } state_t;

  typedef struct packed {
    logic signed [OPW-1:0] a;
    logic signed [OPW-1:0] b;
  } pair_t;

endpackage

// File: rtl/mac_job_seq_if.sv
// Bundle of job, operand, MAC-side and result signals of the job sequencer.
// slave = sequencer view, master = controller/MAC environment view.
interface mac_job_seq_if #(
  parameter int LEN_W = 8
);
  import mac_ctrl_pkg::*;

  logic                     job_start;
  logic [LEN_W-1:0]         job_len;
  logic                     job_busy;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OPW-1:0]    in_a;
  logic signed [OPW-1:0]    in_b;
  logic                     mac_clr;
  logic                     mac_valid;
  logic signed [OPW-1:0]    mac_a;
  logic signed [OPW-1:0]    mac_b;
  logic signed [ACCW-1:0]   mac_y;
  logic                     mac_done;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [ACCW-1:0]   res_y;
  logic [LEN_W-1:0]         res_count;
  logic                     timeout_err;

  modport slave (
    input  job_start, job_len, in_valid, in_a, in_b, mac_y, mac_done, res_ready,
    output job_busy, in_ready, mac_clr, mac_valid, mac_a, mac_b,
           res_valid, res_y, res_count, timeout_err
  );

  modport master (
    output job_start, job_len, in_valid, in_a, in_b, mac_y, mac_done, res_ready,
    input  job_busy, in_ready, mac_clr, mac_valid, mac_a, mac_b,
           res_valid, res_y, res_count, timeout_err
  );

endinterface

// File: rtl/mac_op_fifo.sv
// Synchronous FIFO of operand pairs with registered full/empty flags.
// Head entry is visible combinationally from the storage array.
module mac_op_fifo
  import mac_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  pair_t din,
  output pair_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("mac_op_fifo: DEPTH must be a power of two >= 2");
  end

  pair_t          mem [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_n;

  always_comb begin
    cnt_n = cnt_q;
    case ({push, pop})
      2'b10:   cnt_n = cnt_q + 1'b1;
      2'b01:   cnt_n = cnt_q - 1'b1;
      default: cnt_n = cnt_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_n;
      full  <= (cnt_n == CW'(DEPTH));
      empty <= (cnt_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end

  assign head = mem[rd_q];

endmodule

// File: rtl/mac_job_seq.sv
// Job sequencer: buffers operand pairs, clears the MAC, issues one pair per
// transaction and returns the final sum. Optional watchdog: MAC_TIMEOUT_EN.
module mac_job_seq
  import mac_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  mac_job_seq_if.slave  bus
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mac_job_seq: TIMEOUT must be >= 1");
  end

  state_t                  state;
  state_t                  state_n;
  pair_t                   din;
  pair_t                   head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    stg_ok;
  logic signed [OPW-1:0]   mac_a_q;
  logic signed [OPW-1:0]   mac_b_q;
  logic                    mac_clr_q;
  logic                    res_valid_q;
  logic signed [ACCW-1:0]  res_y_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt_q;
  logic [LEN_W-1:0]        cnt_inc;
  logic                    terr_q;
  logic                    wd_hit;
  logic                    fire;

  assign din.a   = bus.in_a;
  assign din.b   = bus.in_b;
  assign push    = bus.in_valid && !fifo_full;
  assign cnt_inc = cnt_q + 1'b1;

  mac_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.job_start) state_n = (bus.job_len == '0) ? RESULT : CLEAR;
      end
      CLEAR: state_n = ISSUE;
      ISSUE: begin
        if (stg_ok) begin
          pop     = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.mac_done) begin
          state_n = (cnt_inc == len_q) ? RESULT : ISSUE;
        end else if (wd_hit) begin
          fire    = 1'b1;
          state_n = RESULT;
        end
      end
      RESULT: begin
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Head is copied into the launch register ahead of time so the operands are
  // already registered in the launch cycle; stg_ok marks that copy as current.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_ok  <= 1'b0;
      mac_a_q <= '0;
      mac_b_q <= '0;
    end else if (state_n == WAIT) begin
      stg_ok  <= 1'b0;
    end else if (!fifo_empty) begin
      stg_ok  <= 1'b1;
      mac_a_q <= head.a;
      mac_b_q <= head.b;
    end else begin
      stg_ok  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mac_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      terr_q      <= 1'b0;
    end else begin
      mac_clr_q   <= (state_n == CLEAR) || fire;
      res_valid_q <= (state_n == RESULT);
      if (state == IDLE && bus.job_start) begin
        len_q   <= bus.job_len;
        cnt_q   <= '0;
        res_y_q <= '0;
        terr_q  <= 1'b0;
      end else if (state == WAIT && bus.mac_done) begin
        res_y_q <= bus.mac_y;
        cnt_q   <= cnt_inc;
      end else if (fire) begin
        terr_q  <= 1'b1;
      end
    end
  end

`ifdef MAC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q;

  // Watchdog restarts on every launch and only advances while waiting.
  always_ff @(posedge clk) begin
    if (reset)              wd_q <= '0;
    else if (pop)           wd_q <= '0;
    else if (state == WAIT) wd_q <= wd_q + 1'b1;
  end

  assign wd_hit = (state == WAIT) && (wd_q == TW'(TIMEOUT - 1));
`else
  assign wd_hit = 1'b0;
`endif

  assign bus.job_busy    = (state != IDLE);
  assign bus.in_ready    = !fifo_full;
  assign bus.mac_clr     = mac_clr_q;
  assign bus.mac_valid   = pop;
  assign bus.mac_a       = mac_a_q;
  assign bus.mac_b       = mac_b_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_y       = res_y_q;
  assign bus.res_count   = cnt_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mac_job_seq.sv
// Self-checking bench for mac_job_seq with a behavioural MAC and a result
// scoreboard; the watchdog case runs when MAC_TIMEOUT_EN is defined.
module tb_mac_job_seq;
  import mac_ctrl_pkg::*;

  localparam int LEN_W = 8;

  typedef struct {
    logic signed [31:0] y;
    logic [LEN_W-1:0]   cnt;
    logic               terr;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mac_job_seq_if #(.LEN_W(LEN_W)) bus();

  mac_job_seq #(
    .DEPTH   (4),
    .LEN_W   (LEN_W),
    .TIMEOUT (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];

  // Behavioural MAC: product added after mac_lat+1 cycles, cleared by mac_clr.
  logic signed [31:0] acc = 0;
  logic signed [31:0] prod = 0;
  logic busy       = 1'b0;
  logic model_done = 1'b0;
  logic inj_done   = 1'b0;
  logic mac_en     = 1'b1;
  int   mac_lat    = 0;
  int   lat_cnt    = 0;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (reset || bus.mac_clr) begin
      acc  <= 0;
      busy <= 1'b0;
    end else if (busy) begin
      if (lat_cnt == 0) begin
        if (mac_en) begin
          acc        <= acc + prod;
          model_done <= 1'b1;
          busy       <= 1'b0;
        end
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end else if (bus.mac_valid) begin
      prod    <= bus.mac_a * bus.mac_b;
      busy    <= 1'b1;
      lat_cnt <= mac_lat;
    end
  end

  assign bus.mac_done = model_done | inj_done;
  assign bus.mac_y    = acc;

  int   n_valid   = 0;
  int   n_clr     = 0;
  int   gap_err   = 0;
  logic prev_done = 1'b0;
  logic prev_clr  = 1'b0;
  logic gap_chk   = 1'b0;

  always @(posedge clk) begin
    if (bus.mac_valid) n_valid <= n_valid + 1;
    if (bus.mac_clr)   n_clr   <= n_clr + 1;
    if (gap_chk && bus.mac_valid && !prev_done && !prev_clr) gap_err <= gap_err + 1;
    prev_done <= bus.mac_done;
    prev_clr  <= bus.mac_clr;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic signed [15:0] a, input logic signed [15:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic start_job(input logic [LEN_W-1:0] len, input logic signed [31:0] y,
                           input logic [LEN_W-1:0] c, input logic t);
    exp_t e;
    e.y = y; e.cnt = c; e.terr = t;
    sb.push_back(e);
    bus.job_start = 1'b1;
    bus.job_len   = len;
    step();
    bus.job_start = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   n = 0;
    while (!bus.res_valid && n < 400) begin
      step();
      n++;
    end
    check({tag, "_res_valid"}, 32'(bus.res_valid), 1);
    if (sb.size() == 0) begin
      check({tag, "_sb_entries"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_res_y"},       bus.res_y,              e.y);
      check({tag, "_res_count"},   32'(bus.res_count),     32'(e.cnt));
      check({tag, "_timeout_err"}, 32'(bus.timeout_err),   32'(e.terr));
    end
  endtask

  task automatic handshake(input string tag);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check({tag, "_res_valid_after_ack"}, 32'(bus.res_valid), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_job_busy"},    32'(bus.job_busy),    0);
    check({tag, "_mac_clr"},     32'(bus.mac_clr),     0);
    check({tag, "_mac_valid"},   32'(bus.mac_valid),   0);
    check({tag, "_mac_a"},       32'(bus.mac_a),       0);
    check({tag, "_mac_b"},       32'(bus.mac_b),       0);
    check({tag, "_res_valid"},   32'(bus.res_valid),   0);
    check({tag, "_res_y"},       bus.res_y,            0);
    check({tag, "_res_count"},   32'(bus.res_count),   0);
    check({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
    check({tag, "_in_ready"},    32'(bus.in_ready),    1);
  endtask

  initial begin
    #500000;
    $display("FAIL tb_time_limit observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int cv, cc, n, accepted, unstable;
    logic signed [31:0] y0;

    bus.job_start = 1'b0;
    bus.job_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;

    repeat (2) step();
    reset = 1'b0;
    check_zero_outputs("reset");

    // Prefilled dot product; check launch latency and back-to-back issue.
    push_pair(30, 40);
    push_pair(10, 16);
    push_pair(50, 25);
    cv = n_valid; cc = n_clr;
    gap_chk = 1'b1;
    start_job(3, 2610, 3, 1'b0);
    check("t1_clr_at_T1",   32'(bus.mac_clr),   1);
    check("t1_valid_at_T1", 32'(bus.mac_valid), 0);
    check("t1_busy",        32'(bus.job_busy),  1);
    step();
    check("t1_valid_at_T2", 32'(bus.mac_valid), 1);
    check("t1_clr_at_T2",   32'(bus.mac_clr),   0);
    check("t1_mac_a",       32'(bus.mac_a),     30);
    check("t1_mac_b",       32'(bus.mac_b),     40);
    wait_result("t1");
    check("t1_launches",    n_valid - cv, 3);
    check("t1_clears",      n_clr - cc,   1);
    check("t1_issue_gap",   gap_err,      0);
    gap_chk = 1'b0;
    handshake("t1");
    check("t1_busy_after",  32'(bus.job_busy), 0);

    // Mixed-sign pairs streamed in after the job starts, slower MAC.
    mac_lat = 2;
    cc = n_clr;
    start_job(3, -99, 3, 1'b0);
    push_pair(100, -2);
    push_pair(11, -11);
    push_pair(-111, -2);
    wait_result("t2");
    check("t2_clears", n_clr - cc, 1);
    handshake("t2");

    // Zero-length job: immediate result, no MAC activity.
    cv = n_valid; cc = n_clr;
    start_job(0, 0, 0, 1'b0);
    check("t3_res_valid_next", 32'(bus.res_valid), 1);
    wait_result("t3");
    check("t3_launches", n_valid - cv, 0);
    check("t3_clears",   n_clr - cc,   0);
    handshake("t3");

    // Overfill the FIFO while idle, then hold the result under back-pressure.
    mac_lat = 1;
    accepted = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_a = 16'(2 * i + 1);
      bus.in_b = 16'(2 * i + 2);
      if (bus.in_ready) accepted++;
      step();
    end
    bus.in_valid = 1'b0;
    check("t4_accepted",      accepted, 4);
    check("t4_in_ready_full", 32'(bus.in_ready), 0);
    start_job(4, 100, 4, 1'b0);
    wait_result("t4");
    y0 = bus.res_y;
    unstable = 0;
    bus.job_start = 1'b1;
    bus.job_len   = 8'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      bus.job_start = 1'b0;
      if (!bus.res_valid || bus.res_y !== y0 || bus.res_count !== 8'd4) unstable++;
    end
    check("t4_hold_stable", unstable, 0);
    check("t4_busy_hold",   32'(bus.job_busy), 1);
    handshake("t4");
    step();
    check("t4_ignored_start_busy",  32'(bus.job_busy),  0);
    check("t4_ignored_start_valid", 32'(bus.res_valid), 0);
    check("t4_in_ready_drained",    32'(bus.in_ready),  1);

    // Reset while waiting on the MAC abandons the job and flushes the FIFO.
    mac_en = 1'b0;
    push_pair(5, 5);
    push_pair(6, 6);
    bus.job_start = 1'b1;
    bus.job_len   = 8'd2;
    step();
    bus.job_start = 1'b0;
    n = 0;
    while (!bus.mac_valid && n < 20) begin
      step();
      n++;
    end
    check("t5_launch", 32'(bus.mac_valid), 1);
    repeat (3) step();
    check("t5_busy_in_wait", 32'(bus.job_busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mac_en = 1'b1;
    check_zero_outputs("t5_reset");
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    step();
    check("t5_late_done_valid", 32'(bus.res_valid), 0);
    check("t5_late_done_busy",  32'(bus.job_busy),  0);
    check("t5_late_done_count", 32'(bus.res_count), 0);
    push_pair(3, 3);
    start_job(1, 9, 1, 1'b0);
    wait_result("t5");
    handshake("t5");

`ifdef MAC_TIMEOUT_EN
    // MAC never completes: watchdog ends the job after TIMEOUT wait cycles.
    push_pair(7, 7);
    mac_en = 1'b0;
    cc = n_clr;
    start_job(1, 0, 0, 1'b1);
    n = 0;
    while (!bus.mac_valid && n < 20) begin
      step();
      n++;
    end
    check("t6_launch", 32'(bus.mac_valid), 1);
    n = 0;
    while (!bus.res_valid && n < 200) begin
      step();
      n++;
    end
    check("t6_wait_cycles",  n, 65);
    check("t6_timeout_clr",  32'(bus.mac_clr), 1);
    wait_result("t6");
    check("t6_clears", n_clr - cc, 2);
    mac_en = 1'b1;
    handshake("t6");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
